// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and multiplier controller state encoding.
package alu_pkg;

  localparam int unsigned OP_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/adder_64bit.sv
// 64-bit ripple-carry adder; the multiplier sequencer's datapath adder.
module adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        cout
);

  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    for (int i = 0; i < 64; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle unsigned 32x32->64 shift-and-add multiplier driving adder_64bit.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_mul_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned OP_W  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  input  logic              abort,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*OP_W-1:0] product,
  output logic              busy
);

  // The product width is tied to the fixed 64-bit adder.
  if (OP_W != 32) begin : g_bad_op_w
    $error("shift_add_mul_ctrl: OP_W must be 32");
  end
  if ((2 ** CNT_W) != OP_W) begin : g_bad_cnt_w
    $error("shift_add_mul_ctrl: 2**CNT_W must equal OP_W");
  end

  logic [1:0]        r_state;
  logic [63:0]       r_acc;
  logic [63:0]       r_mcand;
  logic [OP_W-1:0]   r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_state_d;
  logic [63:0]       w_acc_d;
  logic [63:0]       w_mcand_d;
  logic [OP_W-1:0]   w_mplier_d;
  logic [CNT_W-1:0]  w_cnt_d;

  logic [63:0]       w_addend;
  logic [63:0]       w_sum;
  logic              w_cout;
  logic [OP_W-1:0]   w_mplier_shr;

  assign w_addend     = r_mplier[0] ? r_mcand : 64'd0;
  assign w_mplier_shr = r_mplier >> 1;

  adder_64bit u_adder (
    .a    (r_acc),
    .b    (w_addend),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_cnt_d    = r_cnt;
    // abort only redirects the FSM; datapath registers keep their contents
    if (abort) begin
      w_state_d = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            w_mcand_d  = {{(64-OP_W){1'b0}}, op_a};
            w_mplier_d = op_b;
            w_acc_d    = '0;
            w_cnt_d    = '0;
            w_state_d  = S_RUN;
          end
        end
        S_RUN: begin
          w_acc_d    = w_sum;
          w_mcand_d  = r_mcand << 1;
          w_mplier_d = w_mplier_shr;
          w_cnt_d    = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(OP_W - 1)) begin
            w_state_d = S_DONE;
          end
`ifdef MUL_EARLY_EXIT_EN
          if (w_mplier_shr == '0) begin
            w_state_d = S_DONE;
          end
`endif
        end
        S_DONE: begin
          if (res_ready) begin
            w_state_d = S_IDLE;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign product     = r_acc;

  // Partial sums never exceed the final product, so a carry out means a datapath fault.
  a_no_cout : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_RUN) |-> !w_cout);

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for shift_add_mul_ctrl: directed vectors, queue-based product checking.
module tb_shift_add_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        abort;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  shift_add_mul_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
`ifdef MUL_EARLY_EXIT_EN
    return h + 1;
`else
    h = 32;
    return h;
`endif
  endfunction

  // Monitor: every result handshake pops one expected product.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected no result", product);
      end else begin
        chk("product", product, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_ready_before_issue", {63'd0, start_ready}, 64'd1);
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input int hold, input bit noise);
    int n;
    int bad;
    @(posedge clk); #1;
    wait_ready();
    op_a        = a;
    op_b        = b;
    start_valid = 1'b1;
    res_ready   = (hold == 0);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    // noise: keep a different request asserted through RUN; it must be ignored
    if (noise) begin
      op_a = ~a;
      op_b = 32'h1234;
    end else begin
      start_valid = 1'b0;
    end
    n   = 0;
    bad = 0;
    while (!res_valid && n < 200) begin
      if (start_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      n++;
    end
    start_valid = 1'b0;
    chk("latency", 64'(n), 64'(exp_lat(b)));
    chk("run_flags", 64'(bad), 64'd0);
    for (int k = 0; k < hold; k++) begin
      chk("hold_product", product, exp);
      chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
      chk("hold_start_ready", {63'd0, start_ready}, 64'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_handshake", {62'd0, start_ready, res_valid}, 64'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    abort       = 1'b0;
    res_ready   = 1'b1;
    op_a        = '0;
    op_b        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", product, 64'd0);
    chk("reset_flags", {61'd0, res_valid, busy, start_ready}, 64'd1);
    rst_n = 1'b1;

    do_mul(32'd2, 32'd3, 64'd6, 0, 1'b0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
    do_mul(32'd100, 32'd200, 64'd20000, 5, 1'b0);
    do_mul(32'h1234_5678, 32'h10, 64'h1_2345_6780, 0, 1'b1);

    // abort at RUN cycle 10
    @(posedge clk); #1;
    wait_ready();
    op_a = 32'd11; op_b = 32'hFFFF_0000; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_abort", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_flags", {61'd0, res_valid, busy, start_ready}, 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_result", {63'd0, res_valid}, 64'd0);
    do_mul(32'd7, 32'd9, 64'd63, 0, 1'b0);

    // abort coincident with a request in IDLE blocks acceptance
    @(posedge clk); #1;
    op_a = 32'd1; op_b = 32'd1; start_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_flags", {62'd0, busy, start_ready}, 64'd1);

    // asynchronous reset at RUN cycle 20
    @(posedge clk); #1;
    wait_ready();
    op_a = 32'd3; op_b = 32'h8000_0001; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    chk("busy_before_reset", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_product", product, 64'd0);
    chk("midrun_reset_flags", {61'd0, res_valid, busy, start_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_mul(32'h4000_0000, 32'd2, 64'h8000_0000, 0, 1'b0);

    do_mul(32'd5, 32'd1, 64'd5, 0, 1'b0);
    do_mul(32'd5, 32'h8000_0000, 64'h2_8000_0000, 0, 1'b0);
    do_mul(32'd12345, 32'd0, 64'd0, 2, 1'b0);
    do_mul(32'hDEAD_BEEF, 32'd1, 64'hDEAD_BEEF, 0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
